// File: rtl/pvr_f2f_pkg.sv
//=============================================================================
// Module   : pvr_f2f_pkg
// Purpose  : Shared constants, value classes and per-lane stage payloads for
//            the pipelined float-to-fixed converter (pvr_f2f_pipe).
// Revision : 1.0 - initial multi-lane pipelined release
//=============================================================================
`default_nettype none

package pvr_f2f_pkg;

   localparam int FP_EXP_BIAS = 127;
   localparam int FP_MAN_W    = 23;
   localparam int FP_EXP_MAX  = 255;

   // Widest supported output lane; stage payloads are sized for it.
   localparam int MAG_W       = 48;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } f2f_class_t;

   // S1 payload: unpacked float fields.
   typedef struct packed {
      logic               sign;
      f2f_class_t         cls;
      logic [7:0]         exp;
      logic [FP_MAN_W:0]  man;   // hidden bit included
   } f2f_s1_t;

   // S2 payload: scaled magnitude ready for rounding / saturation.
   typedef struct packed {
      logic               sign;
      f2f_class_t         cls;
      logic               ovf;   // magnitude cannot fit OUT_W bits at all
      logic [MAG_W-1:0]   mag;
      logic               rnd;   // last bit shifted out on a right shift
   } f2f_s2_t;

   // Denormals are flushed to ZERO.
   function automatic f2f_class_t f2f_classify(input logic [7:0] e,
                                               input logic [FP_MAN_W-1:0] f);
      f2f_class_t cls;
      if (e == 8'd0)
         cls = ZERO;
      else if (e == 8'(FP_EXP_MAX))
         cls = (f == '0) ? INF : NAN;
      else
         cls = NORM;
      return cls;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pvr_f2f_lane.sv
//=============================================================================
// Module   : pvr_f2f_lane
// Purpose  : Three-stage datapath converting one IEEE-754 single to a signed
//            OUT_W-bit fixed-point value. No valid logic: every stage loads
//            when en_i is high.
// Ports    : clock, reset_n  - clock / async active-low reset
//            en_i            - common pipeline advance enable
//            fp_i            - input float (captured into S1)
//            frac_i          - clamped fractional bits, already aligned to S1
//            data_o, sat_o   - registered S3 result and saturation flag
// Options  : PVR_F2F_ROUND_EN - round to nearest, ties away from zero;
//                               otherwise truncate toward zero.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module pvr_f2f_lane
   import pvr_f2f_pkg::*;
#(
   parameter int OUT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic [31:0]      fp_i,
   input  logic [5:0]       frac_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);

   localparam logic [9:0]       SH_BIAS = 10'(FP_EXP_BIAS + FP_MAN_W);
   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   // Magnitude limits in OUT_W+1 bits; the negative side admits 2^(OUT_W-1).
   localparam logic [OUT_W:0]   LIM_POS = {2'b00, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W:0]   LIM_NEG = {2'b01, {(OUT_W-1){1'b0}}};

   f2f_s1_t          s1_d, s1_q;
   f2f_s2_t          s2_d, s2_q;
   logic [OUT_W-1:0] data_d, data_q;
   logic             sat_d, sat_q;

   logic [9:0]       sh;
   logic [9:0]       nsh;
   logic [OUT_W+23:0] wide;
   logic [OUT_W:0]   mag_r;
   logic [OUT_W:0]   neg;

   // S1: unpack
   always_comb begin
      s1_d.sign = fp_i[31];
      s1_d.exp  = fp_i[30:23];
      s1_d.man  = {1'b1, fp_i[22:0]};
      s1_d.cls  = f2f_classify(fp_i[30:23], fp_i[22:0]);
   end

   // S2: scale by 2^(e - 150 + frac). sh is a 10-bit two's-complement value.
   always_comb begin
      sh        = 10'(s1_q.exp) - SH_BIAS + 10'(frac_i);
      nsh       = 10'(0) - sh;
      wide      = {{OUT_W{1'b0}}, s1_q.man} << sh[5:0];
      s2_d.sign = s1_q.sign;
      s2_d.cls  = s1_q.cls;
      s2_d.ovf  = 1'b0;
      s2_d.mag  = '0;
      s2_d.rnd  = 1'b0;
      if (!sh[9]) begin
         // Bit OUT_W-1 is kept in mag so S3 can accept exactly -2^(OUT_W-1);
         // anything above it, or a shift past the lane, can never fit.
         s2_d.ovf = (sh >= 10'(OUT_W)) || (|wide[OUT_W+23:OUT_W]);
         s2_d.mag = MAG_W'(wide[OUT_W-1:0]);
      end else if (nsh < 10'd25) begin
         s2_d.mag = MAG_W'(s1_q.man >> nsh[4:0]);
`ifdef PVR_F2F_ROUND_EN
         s2_d.rnd = s1_q.man[5'(nsh[4:0] - 5'd1)];
`endif
      end
   end

   // S3: round, saturate, negate, special values
   always_comb begin
      mag_r  = {1'b0, s2_q.mag[OUT_W-1:0]} + (OUT_W+1)'(s2_q.rnd);
      neg    = ~mag_r + 1'b1;
      data_d = '0;
      sat_d  = 1'b0;
      case (s2_q.cls)
         ZERO: begin
            data_d = '0;
            sat_d  = 1'b0;
         end
         NAN: begin
            data_d = '0;
            sat_d  = 1'b1;
         end
         INF: begin
            data_d = s2_q.sign ? MIN_NEG : MAX_POS;
            sat_d  = 1'b1;
         end
         default: begin
            if (s2_q.sign) begin
               if (s2_q.ovf || (mag_r > LIM_NEG)) begin
                  data_d = MIN_NEG;
                  sat_d  = 1'b1;
               end else begin
                  data_d = neg[OUT_W-1:0];
               end
            end else begin
               if (s2_q.ovf || (mag_r > LIM_POS)) begin
                  data_d = MAX_POS;
                  sat_d  = 1'b1;
               end else begin
                  data_d = mag_r[OUT_W-1:0];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         data_q <= '0;
         sat_q  <= 1'b0;
      end else if (en_i) begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         data_q <= data_d;
         sat_q  <= sat_d;
      end
   end

   assign data_o = data_q;
   assign sat_o  = sat_q;

endmodule

`default_nettype wire

// File: rtl/pvr_f2f_pipe.sv
//=============================================================================
// Module   : pvr_f2f_pipe
// Purpose  : Pipelined NUM_CH-lane float-to-signed-fixed converter with
//            valid/ready flow control, tag passthrough and a saturating
//            saturation-event counter. Latency 3, throughput 1/cycle.
// Ports    : clock, reset_n          - clock / async active-low reset
//            frac_bits               - fractional bits (clamped to MAX_FRAC)
//            in_valid/in_ready       - input handshake
//            in_data, in_tag         - packed floats and sideband tag
//            out_valid/out_ready     - output handshake
//            out_data, out_tag       - packed fixed results and their tag
//            out_sat                 - per-lane saturation flags
//            clr_stats, sat_count    - counter clear / saturation count
// Options  : PVR_F2F_ROUND_EN (in pvr_f2f_lane) selects rounding.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module pvr_f2f_pipe
   import pvr_f2f_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int OUT_W    = 32,
   parameter int TAG_W    = 8,
   parameter int MAX_FRAC = 31
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [5:0]              frac_bits,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_CH*32-1:0]    in_data,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH*OUT_W-1:0] out_data,
   output logic [TAG_W-1:0]        out_tag,
   output logic [NUM_CH-1:0]       out_sat,
   input  logic                    clr_stats,
   output logic [15:0]             sat_count
);

   logic             en;
   logic [5:0]       frac_d, frac_q;
   logic [2:0]       vld_q;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
   logic [15:0]      cnt_d, cnt_q;
   logic [16:0]      cnt_sum;
   logic [15:0]      pop;

   // Whole pipe advances unless a valid output is being held back.
   assign en       = !vld_q[2] || out_ready;
   assign in_ready = en;
   assign frac_d   = (frac_bits > 6'(MAX_FRAC)) ? 6'(MAX_FRAC) : frac_bits;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q  <= '0;
         frac_q <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
         tag3_q <= '0;
      end else if (en) begin
         vld_q  <= {vld_q[1:0], in_valid};
         frac_q <= frac_d;
         tag1_q <= in_tag;
         tag2_q <= tag1_q;
         tag3_q <= tag2_q;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      pvr_f2f_lane #(
         .OUT_W (OUT_W)
      ) u_lane (
         .clock   (clock),
         .reset_n (reset_n),
         .en_i    (en),
         .fp_i    (in_data[32*g +: 32]),
         .frac_i  (frac_q),
         .data_o  (out_data[OUT_W*g +: OUT_W]),
         .sat_o   (out_sat[g])
      );
   end

   // Counter: clear wins over the same-cycle increment; sticks at all-ones.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++)
         pop = pop + 16'(out_sat[i]);
      cnt_sum = {1'b0, cnt_q} + {1'b0, pop};
      cnt_d   = cnt_q;
      if (clr_stats)
         cnt_d = '0;
      else if (vld_q[2] && out_ready)
         cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign out_valid = vld_q[2];
   assign out_tag   = tag3_q;
   assign sat_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pvr_f2f_pipe.sv
//=============================================================================
// Module   : tb_pvr_f2f_pipe
// Purpose  : Directed self-checking bench for pvr_f2f_pipe (NUM_CH=3,
//            OUT_W=32). Honours PVR_F2F_ROUND_EN for the rounding vector.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_pvr_f2f_pipe;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [5:0]  frac_bits;
   logic        in_valid;
   logic        in_ready;
   logic [95:0] in_data;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [95:0] out_data;
   logic [7:0]  out_tag;
   logic [2:0]  out_sat;
   logic        clr_stats;
   logic [15:0] sat_count;

   int n_tests = 0;
   int n_fail  = 0;

   pvr_f2f_pipe #(
      .NUM_CH   (3),
      .OUT_W    (32),
      .TAG_W    (8),
      .MAX_FRAC (31)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .frac_bits (frac_bits),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_sat   (out_sat),
      .clr_stats (clr_stats),
      .sat_count (sat_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Floats 1.0 .. 8.0 for the streaming test.
   logic [31:0] fl_tab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

   // Stream transaction t: lanes {0, -(t+1), +(t+1)}
   function automatic logic [95:0] strm_in(input int t);
      logic [31:0] f;
      f = fl_tab[t % 8];
      return {32'h00000000, {1'b1, f[30:0]}, f};
   endfunction

   // At frac 2 the result is value * 4.
   function automatic logic [95:0] strm_exp(input int t);
      int v;
      v = (t + 1) * 4;
      return {32'h00000000, 32'(-v), 32'(v)};
   endfunction

   task automatic send_one(input string nm, input logic [5:0] fr, input logic [95:0] d,
                           input logic [7:0] tg, input logic [95:0] exp_d, input logic [2:0] exp_s);
      int lat;
      frac_bits = fr;
      in_data   = d;
      in_tag    = tg;
      in_valid  = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clock); #1;
         lat++;
      end
      check({nm, "_lat"},  lat,      3);
      check({nm, "_data"}, out_data, exp_d);
      check({nm, "_sat"},  out_sat,  exp_s);
      check({nm, "_tag"},  out_tag,  tg);
   endtask

   initial begin
      int          tx, rx, cyc, vcnt;
      bit          acc_in, prev_stall;
      logic [95:0] prev_data;
      logic [7:0]  prev_tag;
      logic [31:0] r075;

      reset_n   = 1'b0;
      frac_bits = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      clr_stats = 1'b0;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_tag",   out_tag,   0);
      check("rst_sat",   out_sat,   0);
      check("rst_cnt",   sat_count, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("rst_ready", in_ready, 1);

      // 1.0, 0.0, -1.0 at frac 8
      send_one("t1", 6'd8, {32'hBF800000, 32'h00000000, 32'h3F800000}, 8'h11,
               {32'hFFFFFF00, 32'h00000000, 32'h00000100}, 3'b000);
      // -1.5, 2.5, denormal at frac 4
      send_one("t2", 6'd4, {32'h00000001, 32'h40200000, 32'hBFC00000}, 8'h22,
               {32'h00000000, 32'h00000028, 32'hFFFFFFE8}, 3'b000);
`ifdef PVR_F2F_ROUND_EN
      r075 = 32'd2;
`else
      r075 = 32'd1;
`endif
      // 0.75, -0.75, NaN at frac 1
      send_one("t3", 6'd1, {32'h7FC00000, 32'hBF400000, 32'h3F400000}, 8'h33,
               {32'h00000000, 32'(-r075), r075}, 3'b100);
      @(posedge clock); #1;
      check("cnt_t3", sat_count, 1);
      clr_stats = 1'b1;
      @(posedge clock); #1;
      clr_stats = 1'b0;
      check("cnt_clr1", sat_count, 0);

      // 2^40, -inf, -2^31 (exact negative limit) at frac 0
      send_one("t4", 6'd0, {32'hCF000000, 32'hFF800000, 32'h53800000}, 8'h44,
               {32'h80000000, 32'h80000000, 32'h7FFFFFFF}, 3'b011);
      @(posedge clock); #1;
      check("cnt_t4", sat_count, 2);
      clr_stats = 1'b1;
      @(posedge clock); #1;
      clr_stats = 1'b0;
      check("cnt_clr2", sat_count, 0);

      // frac 63 clamps to 31: 1.0, 0.5, -1.0
      send_one("t5", 6'd63, {32'hBF800000, 32'h3F000000, 32'h3F800000}, 8'h55,
               {32'h80000000, 32'h40000000, 32'h7FFFFFFF}, 3'b001);
      @(posedge clock); #1;

      // Streaming with random backpressure
      frac_bits  = 6'd2;
      tx         = 0;
      rx         = 0;
      cyc        = 0;
      acc_in     = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_tag   = '0;
      while (rx < 8 && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
         if (acc_in) tx++;
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data",  out_data,  prev_data);
            check("stall_tag",   out_tag,   prev_tag);
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            check("strm_data", out_data, strm_exp(rx));
            check("strm_tag",  out_tag,  8'hA0 + 8'(rx));
            check("strm_sat",  out_sat,  0);
            rx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_tag   = out_tag;
         in_valid   = (tx < 8);
         in_data    = strm_in(tx);
         in_tag     = 8'hA0 + 8'(tx);
         #1;
         acc_in = in_valid && in_ready;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("strm_count", rx, 8);
      vcnt = 0;
      repeat (5) begin
         @(posedge clock); #1;
         if (out_valid) vcnt++;
      end
      check("strm_no_dup", vcnt, 0);

      // Reset with a full, stalled pipeline
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = strm_in(i);
         in_tag  = 8'hC0 + 8'(i);
         @(posedge clock); #1;
      end
      check("pre_rst_valid", out_valid, 1);
      #2;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data",  out_data,  0);
      check("mid_rst_tag",   out_tag,   0);
      check("mid_rst_cnt",   sat_count, 0);
      @(posedge clock); #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      check("post_rst_ready", in_ready, 1);
      vcnt = 0;
      repeat (5) begin
         @(posedge clock); #1;
         if (out_valid) vcnt++;
      end
      check("post_rst_no_out", vcnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
